// File: rtl/micro_hash_pkg.sv
// Shared constants and state type for the micro hash miner controller and its helpers.
package micro_hash_pkg;

   localparam int BYTE            = 8;
   localparam int PAYLOAD_BYTES   = 12;
   localparam int NONCE_LSB_BYTE  = 12;
   localparam int BLOCK_BYTES     = 16;
   localparam int HASH_BYTES      = 3;
   localparam int DEFAULT_TIMEOUT = 127;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/micro_hash_miner_ctrl_if.sv
// Controller <-> hash core bus: block/next/finished towards the core, h/valid_out back.
interface micro_hash_miner_ctrl_if #(
   parameter int BYTE = micro_hash_pkg::BYTE
) ();

   logic [16*BYTE-1:0] block;
   logic               next;
   logic               finished;
   logic [3*BYTE-1:0]  h;
   logic               valid_out;

   modport master (output block, output next, output finished, input h, input valid_out);
   modport slave  (input block, input next, input finished, output h, output valid_out);

endinterface

// File: rtl/micro_hash_block_builder.sv
// Packs a 12-byte payload and a 32-bit nonce (little-endian, bytes 12..15) into a core block.
module micro_hash_block_builder
   import micro_hash_pkg::*;
#(
   parameter int BYTE = micro_hash_pkg::BYTE
) (
   input  logic [PAYLOAD_BYTES*BYTE-1:0] i_payload,
   input  logic [31:0]                   i_nonce,
   output logic [BLOCK_BYTES*BYTE-1:0]   o_block
);

   assign o_block[PAYLOAD_BYTES*BYTE-1:0] = i_payload;

   // Each nonce octet lands in its own byte lane, zero-extended when BYTE is wider than 8.
   for (genvar b = 0; b < 4; b++) begin : g_nonce
      assign o_block[(NONCE_LSB_BYTE+b)*BYTE +: BYTE] = BYTE'(i_nonce[b*8 +: 8]);
   end

endmodule

// File: rtl/micro_hash_miner_ctrl.sv
// Nonce-search controller: sequences one hash core through LOAD/RUN attempts until the
// target is met, the nonce range is exhausted, or the core stops answering.
module micro_hash_miner_ctrl
   import micro_hash_pkg::*;
#(
   parameter int BYTE    = micro_hash_pkg::BYTE,
   parameter int TIMEOUT = micro_hash_pkg::DEFAULT_TIMEOUT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [12*BYTE-1:0]   payload,
   input  logic [31:0]          nonce_start,
   input  logic [31:0]          nonce_last,
   input  logic [BYTE-1:0]      target,
   micro_hash_miner_ctrl_if.master core,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic                 timeout_err,
   output logic [31:0]          nonce_out,
   output logic [3*BYTE-1:0]    hash_out,
   output logic [31:0]          attempts
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT - 1);

   state_e                r_state;
   logic [12*BYTE-1:0]    r_payload;
   logic [31:0]           r_nonce;
   logic [31:0]           r_nonce_last;
   logic [BYTE-1:0]       r_target;
   logic [7:0]            r_tmo_cnt;
   logic                  r_found;
   logic                  r_timeout_err;
   logic [31:0]           r_nonce_out;
   logic [3*BYTE-1:0]     r_hash_out;
   logic [31:0]           r_attempts;
   logic                  w_meet;

   assign w_meet = core.h[3*BYTE-1 -: BYTE] < r_target;

   micro_hash_block_builder #(.BYTE(BYTE)) u_block_builder (
      .i_payload (r_payload),
      .i_nonce   (r_nonce),
      .o_block   (core.block)
   );

   // NOTE: every register uses non-blocking assignments so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_payload     <= '0;
         r_nonce       <= '0;
         r_nonce_last  <= '0;
         r_target      <= '0;
         r_tmo_cnt     <= '0;
         r_found       <= 1'b0;
         r_timeout_err <= 1'b0;
         r_nonce_out   <= '0;
         r_hash_out    <= '0;
         r_attempts    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_payload     <= payload;
                  r_nonce       <= nonce_start;
                  r_nonce_last  <= nonce_last;
                  r_target      <= target;
                  r_attempts    <= '0;
                  r_found       <= 1'b0;
                  r_timeout_err <= 1'b0;
                  r_state       <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  r_state <= ST_IDLE;
               end else begin
                  // The LOAD cycle counts as the first elapsed cycle of the attempt.
                  r_tmo_cnt <= 8'd1;
                  r_state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
               end else if (core.valid_out) begin
                  r_hash_out  <= core.h;
                  r_nonce_out <= r_nonce;
                  r_attempts  <= r_attempts + 32'd1;
                  if (w_meet) begin
                     r_found <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (r_nonce == r_nonce_last) begin
                     r_found <= 1'b0;
                     r_state <= ST_DONE;
                  end else begin
                     r_nonce <= r_nonce + 32'd1;
                     r_state <= ST_LOAD;
                  end
               end else if (r_tmo_cnt == TMO_LIMIT) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_DONE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 8'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign core.next     = (r_state == ST_LOAD);
   assign core.finished = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign busy          = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign done          = (r_state == ST_DONE);
   assign found         = r_found;
   assign timeout_err   = r_timeout_err;
   assign nonce_out     = r_nonce_out;
   assign hash_out      = r_hash_out;
   assign attempts      = r_attempts;

endmodule

// File: tb/tb_micro_hash_miner_ctrl.sv
// Scoreboard bench for micro_hash_miner_ctrl with a behavioural stub hash core.
module tb_micro_hash_miner_ctrl;

   localparam int BYTE    = 8;
   localparam int TIMEOUT = 127;

   typedef struct {
      logic        found;
      logic        tmo;
      logic [31:0] nonce;
      logic [23:0] hash;
      logic [31:0] attempts;
   } result_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [95:0] payload;
   logic [31:0] nonce_start;
   logic [31:0] nonce_last;
   logic [7:0]  target;
   logic        busy;
   logic        done;
   logic        found;
   logic        timeout_err;
   logic [31:0] nonce_out;
   logic [23:0] hash_out;
   logic [31:0] attempts;

   micro_hash_miner_ctrl_if #(.BYTE(BYTE)) core_if ();

   micro_hash_miner_ctrl #(.BYTE(BYTE), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .payload     (payload),
      .nonce_start (nonce_start),
      .nonce_last  (nonce_last),
      .target      (target),
      .core        (core_if),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .timeout_err (timeout_err),
      .nonce_out   (nonce_out),
      .hash_out    (hash_out),
      .attempts    (attempts)
   );

   always #5 clk = ~clk;

   // Scoreboard state and reference-model memory of the last reported attempt.
   result_t      exp_q[$];
   logic [127:0] blk_q[$];
   int           n_vec = 0;
   int           n_err = 0;
   longint       cyc = 0;
   longint       load_cyc = 0;
   int           stub_mode = 2;
   int           stub_delay = 5;
   logic [31:0]  m_nonce_out = '0;
   logic [23:0]  m_hash_out = '0;
   int           stub_cnt = 0;
   logic [31:0]  stub_nonce = '0;
   logic         mon_prev_next = 1'b0;
   result_t      mon_r;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Hash the stub core returns for a nonce; mode 3 means the core never answers.
   function automatic logic [23:0] stub_hash(input logic [31:0] n);
      logic [31:0] x;
      case (stub_mode)
         0:       return (n == 32'd3) ? 24'h051234 : 24'h200000;
         1:       return 24'hFF0000;
         default: begin
            x = n * 32'h9E37_79B1;
            return x[31:8];
         end
      endcase
   endfunction

   // Reference search: walk the nonce range with plain arithmetic until a hit or the end.
   task automatic model_search(input logic [95:0] pl, input logic [31:0] ns, input logic [31:0] nl,
                               input logic [7:0] tg);
      result_t     r;
      logic [31:0] n;
      logic [23:0] hv;
      n          = ns;
      r.found    = 1'b0;
      r.tmo      = 1'b0;
      r.nonce    = m_nonce_out;
      r.hash     = m_hash_out;
      r.attempts = 0;
      if (stub_mode == 3) begin
         blk_q.push_back({n, pl});
         r.tmo = 1'b1;
      end else begin
         forever begin
            hv = stub_hash(n);
            blk_q.push_back({n, pl});
            r.attempts = r.attempts + 1;
            r.nonce    = n;
            r.hash     = hv;
            if (hv[23:16] < tg) begin
               r.found = 1'b1;
               break;
            end
            if (n == nl) break;
            n = n + 1;
         end
      end
      m_nonce_out = r.nonce;
      m_hash_out  = r.hash;
      exp_q.push_back(r);
   endtask

   task automatic launch(input logic [95:0] pl, input logic [31:0] ns, input logic [31:0] nl,
                         input logic [7:0] tg);
      @(negedge clk);
      payload     = pl;
      nonce_start = ns;
      nonce_last  = nl;
      target      = tg;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Scramble inputs and pulse start while the search runs; none of it may take effect.
   task automatic disturb(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (!busy) break;
         payload     = {$urandom, $urandom, $urandom};
         nonce_start = $urandom;
         nonce_last  = $urandom;
         target      = 8'($urandom);
         start       = 1'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_done: search still pending after %0d cycles", budget);
         exp_q.delete();
         blk_q.delete();
         reset = 1'b1;
         @(negedge clk);
         reset       = 1'b0;
         m_nonce_out = '0;
         m_hash_out  = '0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},     busy,          1'b0);
      check({tag, "_done"},     done,          1'b0);
      check({tag, "_found"},    found,         1'b0);
      check({tag, "_tmo"},      timeout_err,   1'b0);
      check({tag, "_nonce"},    nonce_out,     32'd0);
      check({tag, "_hash"},     hash_out,      24'd0);
      check({tag, "_attempts"}, attempts,      32'd0);
      check({tag, "_finished"}, core_if.finished, 1'b1);
      check({tag, "_next"},     core_if.next,  1'b0);
      check({tag, "_block"},    core_if.block, 128'd0);
   endtask

   // Stub core: answers stub_delay+1 negedges after it sees next, using the block's nonce.
   initial begin
      core_if.h         = '0;
      core_if.valid_out = 1'b0;
      forever begin
         @(negedge clk);
         core_if.valid_out = 1'b0;
         if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               core_if.h         = stub_hash(stub_nonce);
               core_if.valid_out = 1'b1;
            end
         end
         if (core_if.next && stub_mode != 3) begin
            stub_nonce = core_if.block[127:96];
            stub_cnt   = stub_delay + 1;
         end
      end
   end

   // Monitor: checks every attempt's block and every done pulse against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_prev_next = 1'b0;
         end else begin
            if (core_if.next) begin
               check("next_one_cycle", mon_prev_next, 1'b0);
               load_cyc = cyc;
               if (blk_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_attempt: block 0x%0h", core_if.block);
               end else begin
                  check("block", core_if.block, blk_q.pop_front());
               end
            end
            mon_prev_next = core_if.next;
            if (done) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_done: found=%0b timeout_err=%0b", found, timeout_err);
               end else begin
                  mon_r = exp_q.pop_front();
                  check("found",       found,       mon_r.found);
                  check("timeout_err", timeout_err, mon_r.tmo);
                  check("nonce_out",   nonce_out,   mon_r.nonce);
                  check("hash_out",    hash_out,    mon_r.hash);
                  check("attempts",    attempts,    mon_r.attempts);
                  check("done_finished", core_if.finished, 1'b1);
                  check("done_busy",   busy,        1'b0);
                  if (mon_r.tmo)
                     check("timeout_latency", 128'(cyc - load_cyc), 128'(TIMEOUT));
               end
            end
         end
      end
   end

   task automatic run_all();
      logic [95:0] pl;
      logic [31:0] ns;
      int          seen;

      reset       = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      payload     = '0;
      nonce_start = '0;
      nonce_last  = '0;
      target      = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Hit on the fourth nonce, with inputs scrambled mid-search.
      stub_mode  = 0;
      stub_delay = 5;
      pl = {$urandom, $urandom, $urandom};
      model_search(pl, 32'd0, 32'd10, 8'h10);
      launch(pl, 32'd0, 32'd10, 8'h10);
      disturb(25);
      wait_done(2000);
      check("t1_found",    found,     1'b1);
      check("t1_nonce",    nonce_out, 32'd3);
      check("t1_hash",     hash_out,  24'h051234);
      check("t1_attempts", attempts,  32'd4);

      // Exhaustion across the 32-bit wrap.
      stub_mode = 1;
      pl = {$urandom, $urandom, $urandom};
      model_search(pl, 32'hFFFF_FFFE, 32'h1, 8'h10);
      launch(pl, 32'hFFFF_FFFE, 32'h1, 8'h10);
      wait_done(2000);
      check("t2_found",    found,     1'b0);
      check("t2_nonce",    nonce_out, 32'd1);
      check("t2_attempts", attempts,  32'd4);

      // Silent core: timeout, previous results held.
      stub_mode = 3;
      pl = {$urandom, $urandom, $urandom};
      model_search(pl, 32'd50, 32'd60, 8'h80);
      launch(pl, 32'd50, 32'd60, 8'h80);
      wait_done(400);
      check("t3_tmo",      timeout_err, 1'b1);
      check("t3_found",    found,       1'b0);
      check("t3_attempts", attempts,    32'd0);
      check("t3_nonce",    nonce_out,   32'd1);

      // Abort two cycles into RUN of the second attempt.
      stub_mode  = 1;
      stub_delay = 5;
      pl = {$urandom, $urandom, $urandom};
      blk_q.push_back({32'd100, pl});
      blk_q.push_back({32'd101, pl});
      launch(pl, 32'd100, 32'd105, 8'h10);
      seen = 1;
      for (int k = 0; k < 200 && seen < 2; k++) begin
         @(negedge clk);
         if (core_if.next) seen++;
      end
      check("t4_second_attempt", seen, 2);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t4_busy",     busy,             1'b0);
      check("t4_finished", core_if.finished, 1'b1);
      check("t4_done",     done,             1'b0);
      check("t4_attempts", attempts,         32'd1);
      check("t4_nonce",    nonce_out,        32'd100);
      m_nonce_out = 32'd100;
      m_hash_out  = 24'hFF0000;
      repeat (12) @(negedge clk);
      check("t4_blocks_drained", blk_q.size(), 0);

      // Randomized searches, including target 0, single-nonce ranges and wraps.
      for (int it = 0; it < 30; it++) begin
         stub_mode  = ($urandom_range(0, 3) == 0) ? 1 : 2;
         stub_delay = $urandom_range(1, 8);
         pl = {$urandom, $urandom, $urandom};
         ns = $urandom;
         if ($urandom_range(0, 3) == 0) ns = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         target = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 8'h60));
         model_search(pl, ns, ns + 32'($urandom_range(0, 5)), target);
         launch(pl, ns, ns + 32'(blk_q.size() == 0 ? 0 : 0) + (blk_q[$][127:96] - ns), target);
         disturb($urandom_range(0, 30));
         wait_done(3000);
      end

      // Reset in the middle of a long search.
      stub_mode  = 1;
      stub_delay = 5;
      pl = {$urandom, $urandom, $urandom};
      model_search(pl, 32'd0, 32'd30, 8'h10);
      launch(pl, 32'd0, 32'd30, 8'h10);
      repeat (20) @(negedge clk);
      check("t7_busy_before_reset", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check_reset_values("t7");
      reset = 1'b0;
      exp_q.delete();
      blk_q.delete();
      m_nonce_out = '0;
      m_hash_out  = '0;
      repeat (12) @(negedge clk);

      // Clean search after the reset.
      stub_mode = 2;
      pl = {$urandom, $urandom, $urandom};
      model_search(pl, 32'd7, 32'd12, 8'h40);
      launch(pl, 32'd7, 32'd12, 8'h40);
      wait_done(2000);
   endtask

   initial begin
      run_all();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
